// File: rtl/uart_tx_ext.sv
// Buffered UART transmitter: show-ahead TX FIFO feeding a frame FSM with 5..9 data bits,
// five parity modes, one/two stop bits, optional CTS gating and break generation.
module uart_tx_ext #(
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int BREAK_BITS    = 13
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [3:0]                       i_data_bits,
  input  logic [2:0]                       i_parity_mode,
  input  logic                             i_stop_bits,
  input  logic                             i_cts_enable,
  input  logic                             i_cts_n,
  input  logic                             i_break_req,
  input  logic                             i_fifo_wr_en,
  input  logic [MAX_DATA_BITS-1:0]         i_fifo_wr_data,
  input  logic                             i_fifo_clear,
  input  logic                             i_err_clear,
  output logic                             o_fifo_full,
  output logic                             o_fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level,
  output logic                             o_overflow_error,
  input  logic                             i_tx_strb,
  output logic                             o_tx_strb_en,
  output logic                             o_busy,
  output logic                             o_tx_done,
  output logic                             o_uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(BREAK_BITS+1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK, BREAK_MARK
  } state_t;

  state_t state_reg, state_next;

  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]            level_reg;
  logic                     overflow_reg;
  logic                     push, pop;
  logic [MAX_DATA_BITS-1:0] head;

  logic [MAX_DATA_BITS-1:0] shift_reg;
  logic [3:0]               bits_reg, cnt_reg;
  logic                     par_en_reg, par_bit_reg, two_stop_reg;
  logic [BW-1:0]            brk_cnt_reg;

  logic                     tx_reg, busy_reg, done_reg;
  logic                     tx_next, busy_next, done_next;

  logic [3:0]               cfg_bits;
  logic [2:0]               cfg_mode;
  logic [MAX_DATA_BITS-1:0] bit_mask;
  logic                     data_xor, cfg_par_bit;

  assign o_fifo_full      = (level_reg == LW'(FIFO_DEPTH));
  assign o_fifo_empty     = (level_reg == '0);
  assign o_fifo_level     = level_reg;
  assign o_overflow_error = overflow_reg;
  assign o_uart_tx        = tx_reg;
  assign o_busy           = busy_reg;
  assign o_tx_strb_en     = busy_reg;
  assign o_tx_done        = done_reg;

  // A clear swallows any same-cycle write, including its overflow.
  assign push = i_fifo_wr_en && !o_fifo_full && !i_fifo_clear;
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= i_fifo_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (i_fifo_clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        level_reg <= level_reg + LW'(push) - LW'(pop);
      end
      if (i_fifo_wr_en && o_fifo_full && !i_fifo_clear) overflow_reg <= 1'b1;
      else if (i_err_clear)                              overflow_reg <= 1'b0;
    end
  end

  assign cfg_bits = (i_data_bits < 4'd5) ? 4'd5 :
                    (i_data_bits > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : i_data_bits;
  assign cfg_mode = (i_parity_mode > 3'd4) ? 3'd0 : i_parity_mode;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
      assign bit_mask[gi] = (cfg_bits > 4'(gi));
    end
  endgenerate

  assign data_xor = ^(head & bit_mask);

  always_comb begin
    cfg_par_bit = 1'b0;
    case (cfg_mode)
      3'd1:    cfg_par_bit = data_xor;
      3'd2:    cfg_par_bit = ~data_xor;
      3'd3:    cfg_par_bit = 1'b1;
      default: cfg_par_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bits_reg     <= 4'd5;
      cnt_reg      <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      brk_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        shift_reg    <= head;
        bits_reg     <= cfg_bits;
        cnt_reg      <= '0;
        par_en_reg   <= (cfg_mode != 3'd0);
        par_bit_reg  <= cfg_par_bit;
        two_stop_reg <= i_stop_bits;
      end else if (state_reg == DATA && i_tx_strb) begin
        shift_reg <= shift_reg >> 1;
        cnt_reg   <= cnt_reg + 4'd1;
      end
      if (state_reg == IDLE)                     brk_cnt_reg <= '0;
      else if (state_reg == BREAK && i_tx_strb)  brk_cnt_reg <= brk_cnt_reg + BW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_break_req) begin
          state_next = BREAK;
        end else if (!o_fifo_empty && (!i_cts_enable || !i_cts_n)) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START:  if (i_tx_strb) state_next = DATA;
      DATA: begin
        if (i_tx_strb && cnt_reg == bits_reg - 4'd1)
          state_next = par_en_reg ? PARITY : STOP1;
      end
      PARITY: if (i_tx_strb) state_next = STOP1;
      STOP1:  if (i_tx_strb) state_next = two_stop_reg ? STOP2 : IDLE;
      STOP2:  if (i_tx_strb) state_next = IDLE;
      BREAK: begin
        if (i_tx_strb && brk_cnt_reg == BW'(BREAK_BITS-1)) state_next = BREAK_MARK;
      end
      BREAK_MARK: if (i_tx_strb) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_reg != IDLE);
    done_next = i_tx_strb && ((state_reg == STOP1 && !two_stop_reg) || state_reg == STOP2);
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      PARITY:  tx_next = par_bit_reg;
      BREAK:   tx_next = 1'b0;
      default: tx_next = 1'b1;
    endcase
  end

  // The line therefore shows each bit for exactly the strobe period its state occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Self-checking bench for uart_tx_ext: samples the line once per bit strobe and compares
// decoded frames against a frame model built from the format rules.
module tb_uart_tx_ext;

  localparam int P  = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    i_data_bits;
  logic [2:0]    i_parity_mode;
  logic          i_stop_bits, i_cts_enable, i_cts_n, i_break_req;
  logic          i_fifo_wr_en, i_fifo_clear, i_err_clear, i_tx_strb;
  logic [8:0]    i_fifo_wr_data;
  logic          o_fifo_full, o_fifo_empty, o_overflow_error;
  logic [LW-1:0] o_fifo_level;
  logic          o_tx_strb_en, o_busy, o_tx_done, o_uart_tx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int strb_phase = 0;
  bit cap_q[$];

  uart_tx_ext #(.FIFO_DEPTH(16), .MAX_DATA_BITS(9), .BREAK_BITS(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data_bits(i_data_bits), .i_parity_mode(i_parity_mode), .i_stop_bits(i_stop_bits),
    .i_cts_enable(i_cts_enable), .i_cts_n(i_cts_n), .i_break_req(i_break_req),
    .i_fifo_wr_en(i_fifo_wr_en), .i_fifo_wr_data(i_fifo_wr_data),
    .i_fifo_clear(i_fifo_clear), .i_err_clear(i_err_clear),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty), .o_fifo_level(o_fifo_level),
    .o_overflow_error(o_overflow_error), .i_tx_strb(i_tx_strb), .o_tx_strb_en(o_tx_strb_en),
    .o_busy(o_busy), .o_tx_done(o_tx_done), .o_uart_tx(o_uart_tx)
  );

  always #5 clk = ~clk;

  // Free-running bit strobe, one cycle in P.
  always @(negedge clk) begin
    i_tx_strb  = (strb_phase == P-1);
    strb_phase = (strb_phase + 1) % P;
  end

  // One line sample per strobe: the value shown for the bit period that just ended.
  always @(posedge clk) begin
    bit s;
    s = i_tx_strb;
    #1;
    if (s) cap_q.push_back(o_uart_tx);
    if (o_tx_done) done_cnt++;
  end

  function automatic void model_frame(input logic [8:0] d, input int nb_in, input int pm_in,
                                      input int sb, output logic [15:0] bits, output int len);
    int nb, pm, ones;
    logic p;
    nb = (nb_in < 5) ? 5 : (nb_in > 9) ? 9 : nb_in;
    pm = (pm_in > 4) ? 0 : pm_in;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    bits = '0;
    len = 1;
    for (int i = 0; i < nb; i++) begin
      bits[len] = d[i];
      len++;
    end
    case (pm)
      1:       p = ((ones % 2) == 1);
      2:       p = ((ones % 2) == 0);
      3:       p = 1'b1;
      default: p = 1'b0;
    endcase
    if (pm != 0) begin
      bits[len] = p;
      len++;
    end
    bits[len] = 1'b1;
    len++;
    if (sb != 0) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic grab(input int len, output logic [15:0] bits, output int gap, output bit ok);
    bits = '0;
    gap  = 0;
    ok   = 1'b1;
    while (cap_q.size() > 0 && cap_q[0] == 1'b1) begin
      void'(cap_q.pop_front());
      gap++;
    end
    if (cap_q.size() < len) ok = 1'b0;
    else for (int i = 0; i < len; i++) bits[i] = cap_q.pop_front();
  endtask

  task automatic set_cfg(input int nb, input int pm, input int sb);
    @(negedge clk);
    i_data_bits   = 4'(nb);
    i_parity_mode = 3'(pm);
    i_stop_bits   = (sb != 0);
  endtask

  task automatic push_word(input logic [8:0] d);
    @(negedge clk);
    i_fifo_wr_en   = 1'b1;
    i_fifo_wr_data = d;
    @(negedge clk);
    i_fifo_wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int  stable;
    bit  ok;
    stable = 0;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (!o_busy && o_fifo_empty) stable++;
      else stable = 0;
      if (stable >= 3) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b empty=%0b, required idle within budget", name, o_busy, o_fifo_empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 8;
    if (o_uart_tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", o_uart_tx); end
    if (o_busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_tx_strb_en !== 1'b0)     begin errors++; $display("FAIL reset_strb_en: got %b want 0", o_tx_strb_en); end
    if (o_tx_done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", o_tx_done); end
    if (o_overflow_error !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow_error); end
    if (o_fifo_level !== '0)       begin errors++; $display("FAIL reset_level: got %0d want 0", o_fifo_level); end
    if (o_fifo_empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", o_fifo_empty); end
    if (o_fifo_full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", o_fifo_full); end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic [15:0] bits, eb;
    int gap, el, d0;
    bit ok;
    set_cfg(8, 0, 0);
    cap_q.delete();
    d0 = done_cnt;
    push_word(9'h055);
    wait_idle("basic");
    model_frame(9'h055, 8, 0, 0, eb, el);
    grab(el, bits, gap, ok);
    checks += 4;
    if (!ok || bits !== eb) begin errors++; $display("FAIL basic_frame: got %b want %b", bits, eb); end
    if (bits[9:0] !== 10'b1010101010) begin errors++; $display("FAIL basic_seq: got %b want 1010101010", bits[9:0]); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", o_busy); end
    $display("test_basic: frame %b done_pulses=%0d", bits[9:0], done_cnt - d0);
  endtask

  task automatic test_parity();
    logic [15:0] bits, eb;
    int gap, el, d0;
    bit ok;
    for (int mode = 1; mode <= 2; mode++) begin
      set_cfg(9, mode, 1);
      cap_q.delete();
      d0 = done_cnt;
      push_word(9'h1A5);
      wait_idle("parity");
      model_frame(9'h1A5, 9, mode, 1, eb, el);
      grab(el, bits, gap, ok);
      checks += 4;
      if (!ok || bits !== eb) begin errors++; $display("FAIL parity_frame mode %0d: got %b want %b", mode, bits, eb); end
      if (bits[10] !== (mode == 1)) begin errors++; $display("FAIL parity_bit mode %0d: got %b want %0b", mode, bits[10], mode == 1); end
      if (bits[12:11] !== 2'b11) begin errors++; $display("FAIL parity_stop mode %0d: got %b want 11", mode, bits[12:11]); end
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL parity_done mode %0d: got %0d want 1", mode, done_cnt - d0); end
      $display("test_parity: mode %0d frame %b", mode, bits[12:0]);
    end
  endtask

  task automatic test_random_frames();
    logic [15:0] bits, eb;
    logic [8:0]  d;
    int gap, el, d0, nb, pm, sb;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      nb = $urandom_range(0, 15);
      pm = $urandom_range(0, 7);
      sb = $urandom_range(0, 1);
      d  = 9'($urandom);
      set_cfg(nb, pm, sb);
      cap_q.delete();
      d0 = done_cnt;
      push_word(d);
      repeat (P * 3) @(negedge clk);
      set_cfg($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1));
      wait_idle("random");
      model_frame(d, nb, pm, sb, eb, el);
      grab(el, bits, gap, ok);
      checks += 2;
      if (!ok || bits !== eb) begin errors++; $display("FAIL random_frame %0d: got %b want %b", n, bits, eb); end
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL random_done %0d: got %0d want 1", n, done_cnt - d0); end
      $display("test_random: n=%0d bits=%0d parity=%0d stop=%0d data=%h frame=%b", n, nb, pm, sb, d, bits);
    end
  endtask

  task automatic test_fifo_full_cts();
    logic [8:0]  words [16];
    logic [15:0] bits, eb;
    int gap, el, d0, zeros;
    bit ok;
    set_cfg(8, 0, 0);
    @(negedge clk);
    i_cts_enable = 1'b1;
    i_cts_n      = 1'b1;
    cap_q.delete();
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) begin
      words[k] = 9'($urandom);
      push_word(words[k]);
    end
    repeat (4) @(negedge clk);
    zeros = 0;
    foreach (cap_q[k]) if (cap_q[k] == 1'b0) zeros++;
    checks += 5;
    if (o_fifo_level !== LW'(16)) begin errors++; $display("FAIL full_level: got %0d want 16", o_fifo_level); end
    if (o_fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", o_fifo_full); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL full_cts_busy: got %b want 0", o_busy); end
    if (zeros != 0) begin errors++; $display("FAIL full_cts_line: got %0d low samples want 0", zeros); end
    if (o_overflow_error !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", o_overflow_error); end
    push_word(9'($urandom));
    checks += 2;
    if (o_overflow_error !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow_error); end
    if (o_fifo_level !== LW'(16)) begin errors++; $display("FAIL ovf_level: got %0d want 16", o_fifo_level); end
    @(negedge clk);
    i_cts_n = 1'b0;
    wait_idle("cts");
    for (int k = 0; k < 16; k++) begin
      model_frame(words[k], 8, 0, 0, eb, el);
      grab(el, bits, gap, ok);
      checks++;
      if (!ok || bits !== eb) begin errors++; $display("FAIL cts_frame %0d: got %b want %b", k, bits, eb); end
      if (k > 0) begin
        checks++;
        if (gap != 0) begin errors++; $display("FAIL cts_b2b %0d: got %0d idle bits want 0", k, gap); end
      end
    end
    checks++;
    if (done_cnt - d0 != 16) begin errors++; $display("FAIL cts_done: got %0d want 16", done_cnt - d0); end
    @(negedge clk);
    i_err_clear = 1'b1;
    @(negedge clk);
    i_err_clear = 1'b0;
    checks++;
    if (o_overflow_error !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow_error); end
    i_cts_enable = 1'b0;
    i_cts_n      = 1'b1;
    $display("test_fifo_full_cts: 16 frames, done_pulses=%0d", done_cnt - d0);
  endtask

  task automatic test_break();
    logic [15:0] bits, eb;
    logic [8:0]  a, b;
    int gap, el, d0, t;
    bit ok;
    set_cfg(8, 0, 0);
    cap_q.delete();
    d0 = done_cnt;
    a = 9'($urandom);
    b = 9'($urandom);
    push_word(a);
    push_word(b);
    repeat (P * 4) @(negedge clk);
    i_break_req = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt == d0) begin errors++; $display("FAIL break_wait_done: got 0 pulses want 1 within budget"); end
    @(negedge clk);
    @(negedge clk);
    i_break_req = 1'b0;
    wait_idle("break");
    model_frame(a, 8, 0, 0, eb, el);
    grab(el, bits, gap, ok);
    checks++;
    if (!ok || bits !== eb) begin errors++; $display("FAIL break_first: got %b want %b", bits, eb); end
    eb = 16'h2000;
    grab(14, bits, gap, ok);
    checks += 2;
    if (!ok || bits !== eb) begin errors++; $display("FAIL break_seq: got %b want %b", bits, eb); end
    if (gap != 0) begin errors++; $display("FAIL break_gap: got %0d want 0", gap); end
    model_frame(b, 8, 0, 0, eb, el);
    grab(el, bits, gap, ok);
    checks += 3;
    if (!ok || bits !== eb) begin errors++; $display("FAIL break_resume: got %b want %b", bits, eb); end
    if (gap != 0) begin errors++; $display("FAIL break_resume_gap: got %0d want 0", gap); end
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL break_done: got %0d want 2", done_cnt - d0); end
    $display("test_break: break sampled, resume frame %b", bits[9:0]);
  endtask

  task automatic test_clear();
    logic [15:0] bits, eb;
    logic [8:0]  a;
    int gap, el, d0, zeros;
    bit ok;
    set_cfg(8, 0, 0);
    cap_q.delete();
    d0 = done_cnt;
    a = 9'($urandom);
    push_word(a);
    push_word(9'($urandom));
    repeat (P * 3) @(negedge clk);
    i_fifo_clear   = 1'b1;
    i_fifo_wr_en   = 1'b1;
    i_fifo_wr_data = 9'($urandom);
    @(negedge clk);
    i_fifo_clear = 1'b0;
    i_fifo_wr_en = 1'b0;
    checks += 3;
    if (o_fifo_level !== '0) begin errors++; $display("FAIL clear_level: got %0d want 0", o_fifo_level); end
    if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %b want 1", o_fifo_empty); end
    if (o_overflow_error !== 1'b0) begin errors++; $display("FAIL clear_ovf: got %b want 0", o_overflow_error); end
    wait_idle("clear");
    model_frame(a, 8, 0, 0, eb, el);
    grab(el, bits, gap, ok);
    zeros = 0;
    foreach (cap_q[k]) if (cap_q[k] == 1'b0) zeros++;
    checks += 3;
    if (!ok || bits !== eb) begin errors++; $display("FAIL clear_frame: got %b want %b", bits, eb); end
    if (zeros != 0) begin errors++; $display("FAIL clear_extra: got %0d low samples want 0", zeros); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL clear_done: got %0d want 1", done_cnt - d0); end
    $display("test_clear: frame %b", bits[9:0]);
  endtask

  task automatic test_reset_mid();
    logic pre_tx;
    int d0, zeros;
    set_cfg(8, 0, 0);
    push_word(9'h000);
    repeat (P * 4) @(negedge clk);
    #2;
    pre_tx = o_uart_tx;
    rst_n  = 1'b0;
    #1;
    checks += 4;
    if (pre_tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got %b want 0", pre_tx); end
    if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", o_uart_tx); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    if (o_tx_strb_en !== 1'b0) begin errors++; $display("FAIL rstmid_strb_en: got %b want 0", o_tx_strb_en); end
    @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    zeros = 0;
    foreach (cap_q[k]) if (cap_q[k] == 1'b0) zeros++;
    checks += 4;
    if (zeros != 0) begin errors++; $display("FAIL rstmid_line: got %0d low samples want 0", zeros); end
    if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", o_fifo_empty); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", o_busy); end
    if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", done_cnt - d0); end
    $display("test_reset_mid: line high, fifo empty");
  endtask

  initial begin
    rst_n          = 1'b0;
    i_tx_strb      = 1'b0;
    i_data_bits    = 4'd8;
    i_parity_mode  = 3'd0;
    i_stop_bits    = 1'b0;
    i_cts_enable   = 1'b0;
    i_cts_n        = 1'b1;
    i_break_req    = 1'b0;
    i_fifo_wr_en   = 1'b0;
    i_fifo_wr_data = '0;
    i_fifo_clear   = 1'b0;
    i_err_clear    = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_random_frames();
    test_fifo_full_cts();
    test_break();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
